// File: rtl/simulation_result_stream_sink.sv
// Result stream sink: arms on DMA_write_valid, stores result_num beats in RAM.
// Keeps beat count and lane checksum; optional BACKPRESSURE_EN adds LFSR stalls.
module simulation_result_stream_sink #(
    parameter int          DATA_WIDTH = 128,
    parameter int          ADDR_WIDTH = 21,
    parameter int          RAM_DEPTH  = 21632,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DMA_write_valid,
    input  logic [ADDR_WIDTH-1:0] result_num,
    input  logic [DATA_WIDTH-1:0] M_Data,
    input  logic                  M_Valid,
    output logic                  M_Ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] beat_cnt,
    output logic [31:0]           checksum,
    output logic                  busy,
    output logic                  done
);
    localparam int LANES  = DATA_WIDTH / 32;
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(RAM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_target;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_ram [RAM_DEPTH];

    logic                  w_accept;
    logic                  w_last;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic [31:0]           w_lane_sum;

`ifdef BACKPRESSURE_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Throttle LFSR: reseeded on arm, steps every cycle spent receiving
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == S_IDLE && DMA_write_valid) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == S_RECV) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    assign M_Ready = r_ready & r_lfsr[0];
`else
    // Seed only matters when the throttle is built in
    logic [15:0] w_unused_seed;
    assign w_unused_seed = LFSR_SEED;

    assign M_Ready = r_ready;
`endif

    assign w_accept  = M_Valid & M_Ready;
    assign w_cnt_nxt = beat_cnt + ADDR_WIDTH'(1);
    assign w_last    = (w_cnt_nxt == r_target);
    assign w_wr_en   = w_accept && (beat_cnt < LP_DEPTH);

    // Sum of all 32-bit lanes of the incoming beat, wrapping mod 2^32
    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + M_Data[32*i +: 32];
        end
    end

    // Control FSM: arm, receive until target reached, one-cycle done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_ready  <= 1'b0;
            beat_cnt <= '0;
            checksum <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (DMA_write_valid) begin
                        r_target <= result_num;
                        beat_cnt <= '0;
                        checksum <= '0;
                        if (result_num == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_RECV;
                            r_ready <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        beat_cnt <= w_cnt_nxt;
                        checksum <= checksum + w_lane_sum;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result RAM write port; beats past the end are dropped, not wrapped
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ram[beat_cnt[RAM_AW-1:0]] <= M_Data;
        end
    end

    // Registered readback, read-first, zero for out-of-range addresses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_addr < LP_DEPTH) begin
            rd_data <= r_ram[rd_addr[RAM_AW-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_simulation_result_stream_sink.sv
// Bench for simulation_result_stream_sink: behavioural model + per-cycle compare.
// Directed scenarios with literal expectations plus randomized transfers.
module tb_simulation_result_stream_sink;
    localparam int          DW    = 128;
    localparam int          AW    = 21;
    localparam int          DEPTH = 21632;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int PH_IDLE = 0;
    localparam int PH_RECV = 1;
    localparam int PH_DONE = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          dwv     = 1'b0;
    logic [AW-1:0] rnum    = '0;
    logic [DW-1:0] mdata   = '0;
    logic          mvalid  = 1'b0;
    logic          mready;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] beat_cnt;
    logic [31:0]   checksum;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b1;

    always #5 clk = ~clk;

    simulation_result_stream_sink dut (
        .clk             (clk),
        .rst             (rst),
        .DMA_write_valid (dwv),
        .result_num      (rnum),
        .M_Data          (mdata),
        .M_Valid         (mvalid),
        .M_Ready         (mready),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .beat_cnt        (beat_cnt),
        .checksum        (checksum),
        .busy            (busy),
        .done            (done)
    );

    // ---------------- behavioural model ----------------
    int            m_ph       = PH_IDLE;
    logic [AW-1:0] m_cnt      = '0;
    logic [AW-1:0] m_tgt      = '0;
    logic [31:0]   m_sum      = '0;
    logic [15:0]   m_lfsr     = SEED;
    logic [DW-1:0] m_rd       = '0;
    bit            m_rd_known = 1'b1;
    bit            m_took     = 1'b0;
    logic [DW-1:0] mem [int];

    function automatic logic [31:0] lane_sum(input logic [DW-1:0] d);
        logic [31:0] s = '0;
        for (int j = 0; j < DW / 32; j++) s = s + d[32*j +: 32];
        return s;
    endfunction

    function automatic logic [DW-1:0] b4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic bit exp_ready();
`ifdef BACKPRESSURE_EN
        return (m_ph == PH_RECV) && m_lfsr[0];
`else
        return (m_ph == PH_RECV);
`endif
    endfunction

    task automatic model_step();
        if (!rst) begin
            m_ph = PH_IDLE;
            m_cnt = '0;
            m_tgt = '0;
            m_sum = '0;
            m_lfsr = SEED;
            m_rd = '0;
            m_rd_known = 1'b1;
            m_took = 1'b0;
            return;
        end
        m_took = 1'b0;
        if (int'(rd_addr) >= DEPTH) begin
            m_rd = '0;
            m_rd_known = 1'b1;
        end else if (mem.exists(int'(rd_addr))) begin
            m_rd = mem[int'(rd_addr)];
            m_rd_known = 1'b1;
        end else begin
            m_rd_known = 1'b0;
        end
        case (m_ph)
            PH_IDLE: begin
                if (dwv) begin
                    m_tgt = rnum;
                    m_cnt = '0;
                    m_sum = '0;
                    m_lfsr = SEED;
                    m_ph = (rnum == '0) ? PH_DONE : PH_RECV;
                end
            end
            PH_RECV: begin
                if (mvalid && exp_ready()) begin
                    if (int'(m_cnt) < DEPTH) mem[int'(m_cnt)] = mdata;
                    m_sum = m_sum + lane_sum(mdata);
                    m_cnt = m_cnt + 1'b1;
                    m_took = 1'b1;
                    if (m_cnt == m_tgt) m_ph = PH_DONE;
                end
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                          m_lfsr[15:1]};
            end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("M_Ready", DW'(mready), DW'(exp_ready()));
            chk("busy", DW'(busy), DW'(m_ph == PH_RECV));
            chk("done", DW'(done), DW'(m_ph == PH_DONE));
            chk("beat_cnt", DW'(beat_cnt), DW'(m_cnt));
            chk("checksum", DW'(checksum), DW'(m_sum));
            if (m_rd_known) chk("rd_data", rd_data, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] src_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int n);
        dwv = 1'b1;
        rnum = AW'(n);
        step();
        dwv = 1'b0;
    endtask

    task automatic run_src(input int maxcyc, output int left);
        int cyc;
        cyc = 0;
        while (src_q.size() > 0 && cyc < maxcyc) begin
            mvalid = 1'b1;
            mdata = src_q[0];
            step();
            cyc++;
            if (m_took) void'(src_q.pop_front());
        end
        mvalid = 1'b0;
        mdata = {4{$urandom}};
        left = src_q.size();
    endtask

    task automatic wait_done(input int maxcyc, input string nm);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c <= maxcyc && !seen; c++) begin
            if (done) seen = 1'b1;
            else if (c < maxcyc) step();
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL %s: done got 0 expected 1 within %0d cycles",
                      nm, maxcyc);
    endtask

    task automatic readback(input int a, input logic [DW-1:0] exp,
                            input string nm);
        rd_addr = AW'(a);
        step();
        chk(nm, rd_data, exp);
    endtask

    // ---------------- scenarios ----------------
    logic [DW-1:0] t1 [4];
    int            left;
    int            stalls;
    longint        nbig;
    bit            ok;

    initial begin
        rst = 1'b0;
        step();
        step();
        chk("rst_beat_cnt", DW'(beat_cnt), DW'(0));
        chk("rst_checksum", DW'(checksum), DW'(0));
        chk("rst_ready", DW'(mready), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_rd_data", rd_data, DW'(0));
        rst = 1'b1;
        step();

        // basic 4-beat transfer
        t1[0] = b4(1, 2, 3, 4);
        t1[1] = b4(5, 6, 7, 8);
        t1[2] = b4(0, 0, 0, 0);
        t1[3] = b4(32'hFFFFFFFF, 1, 0, 0);
        arm(4);
        chk("t1_busy", DW'(busy), DW'(1));
        for (int k = 0; k < 4; k++) src_q.push_back(t1[k]);
        run_src(20, left);
        chk("t1_left", DW'(left), DW'(0));
        chk("t1_done", DW'(done), DW'(1));
        chk("t1_ready_low", DW'(mready), DW'(0));
        chk("t1_beat_cnt", DW'(beat_cnt), DW'(4));
        chk("t1_checksum", DW'(checksum), DW'(32'h24));
        chk("t1_model_sum", DW'(m_sum), DW'(32'h24));
        step();
        chk("t1_done_once", DW'(done), DW'(0));
        for (int k = 0; k < 4; k++) readback(k, t1[k], "t1_rd");

        // source offers 5 beats, only 3 wanted
        arm(3);
        for (int k = 0; k < 5; k++) src_q.push_back(b4(16 + k, 7, 0, 1));
        run_src(8, left);
        src_q.delete();
        chk("t2_not_taken", DW'(left), DW'(2));
        chk("t2_beat_cnt", DW'(beat_cnt), DW'(3));
        readback(3, t1[3], "t2_ram3_kept");

        // zero-length arm
        arm(0);
        chk("t3_busy", DW'(busy), DW'(0));
        wait_done(2, "t3_done");
        chk("t3_beat_cnt", DW'(beat_cnt), DW'(0));
        chk("t3_checksum", DW'(checksum), DW'(0));
        step();

        // reset mid-transfer, then re-arm
        arm(8);
        for (int k = 0; k < 8; k++) src_q.push_back(b4(256 + k, 1, 2, 3));
        run_src(2, left);
        chk("t4_two_in", DW'(left), DW'(6));
        src_q.delete();
        rst = 1'b0;
        #1;
        chk("t4_async_ready", DW'(mready), DW'(0));
        chk("t4_async_busy", DW'(busy), DW'(0));
        step();
        step();
        rst = 1'b1;
        step();
        readback(0, b4(256, 1, 2, 3), "t4_ram_kept");
        arm(2);
        src_q.push_back(b4(10, 20, 30, 40));
        src_q.push_back(b4(1, 2, 3, 4));
        run_src(10, left);
        chk("t4_beat_cnt", DW'(beat_cnt), DW'(2));
        chk("t4_checksum", DW'(checksum), DW'(110));
        readback(0, b4(10, 20, 30, 40), "t4_rd0");
        readback(1, b4(1, 2, 3, 4), "t4_rd1");

        // re-arm during RECV is ignored
        arm(6);
        for (int k = 0; k < 6; k++) src_q.push_back(b4(k, k, k, 9));
        run_src(3, left);
        dwv = 1'b1;
        rnum = AW'(100);
        step();
        dwv = 1'b0;
        run_src(20, left);
        chk("t5_left", DW'(left), DW'(0));
        chk("t5_done", DW'(done), DW'(1));
        chk("t5_beat_cnt", DW'(beat_cnt), DW'(6));

        // 64 incrementing beats, counting stall cycles
        step();
        arm(64);
        for (int k = 0; k < 64; k++)
            src_q.push_back(b4(4 * k, 4 * k + 1, 4 * k + 2, 4 * k + 3));
        stalls = 0;
        for (int c = 0; c < 1000 && src_q.size() > 0; c++) begin
            mvalid = 1'b1;
            mdata = src_q[0];
            if (busy && !mready) stalls++;
            step();
            if (m_took) void'(src_q.pop_front());
        end
        mvalid = 1'b0;
        chk("t6_left", DW'(src_q.size()), DW'(0));
        src_q.delete();
`ifdef BACKPRESSURE_EN
        chk("t6_stalls_seen", DW'(stalls > 0), DW'(1));
`else
        chk("t6_no_stalls", DW'(stalls), DW'(0));
`endif
        chk("t6_beat_cnt", DW'(beat_cnt), DW'(64));
        chk("t6_checksum", DW'(checksum), DW'(32640));
        for (int k = 0; k < 64; k++)
            readback(k, b4(4 * k, 4 * k + 1, 4 * k + 2, 4 * k + 3), "t6_rd");

        // randomized transfers with junk arms, readbacks and idle traffic
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 3; i++) begin
                mvalid = 1'($urandom);
                mdata = {$urandom, $urandom, $urandom, $urandom};
                step();
            end
            arm(int'($urandom_range(1, 20)));
            ok = 1'b0;
            for (int c = 0; c < 400 && !ok; c++) begin
                mvalid = 1'($urandom);
                mdata = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 3) == 0)
                    rd_addr = AW'(DEPTH + int'($urandom_range(0, 5)));
                else
                    rd_addr = AW'($urandom_range(0, 40));
                if ($urandom_range(0, 15) == 0) begin
                    dwv = 1'b1;
                    rnum = AW'($urandom_range(0, 200));
                end
                step();
                dwv = 1'b0;
                if (done) ok = 1'b1;
            end
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL rnd_done: round %0d got 0 expected 1", r);
        end
        mvalid = 1'b0;

        // fill past the end of the RAM
        step();
        nbig = longint'(DEPTH) + 2;
        arm(int'(nbig));
        ok = 1'b0;
        for (int c = 0; c < 4 * DEPTH && !ok; c++) begin
            mvalid = 1'b1;
            mdata = {4{32'(m_cnt)}};
            step();
            if (done) ok = 1'b1;
        end
        mvalid = 1'b0;
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL big_done: got 0 expected 1");
        chk("big_beat_cnt", DW'(beat_cnt), DW'(nbig));
        chk("big_checksum", DW'(checksum), DW'(32'(2 * nbig * (nbig - 1))));
        readback(DEPTH - 1, {4{32'(DEPTH - 1)}}, "big_last_stored");
        readback(DEPTH, DW'(0), "big_out_of_range");

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simulation_result_stream_sink.md
Name: simulation_result_stream_sink

Overview:
- Simulation-side consumer of the accelerator's output stream (M_Data/M_Valid/M_Ready); the write-direction counterpart of the weight/feature stream source.
- Armed by the DMA_write_valid pulse. Accepts exactly result_num 128-bit beats and stores them in an internal result RAM.
- Keeps a beat count and a running checksum, and exposes a 1-cycle-latency readback port so the bench can compare results against golden data.

Parameters:
- DATA_WIDTH, 128, stream beat width; must be a multiple of 32.
- ADDR_WIDTH, 21, result RAM address width and beat-counter width.
- RAM_DEPTH, 21632, number of result RAM entries.
- LFSR_SEED, 16'hACE1, seed of the throttle LFSR; used only with BACKPRESSURE_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- DMA_write_valid  input  1  one-cycle arm pulse.
- result_num  input  ADDR_WIDTH  beats expected; sampled on arm.
- M_Data  input  DATA_WIDTH  stream data from the accelerator.
- M_Valid  input  1  stream valid.
- M_Ready  output  1  sink ready.
- rd_addr  input  ADDR_WIDTH  readback address.
- rd_data  output  DATA_WIDTH  readback data, 1-cycle latency.
- beat_cnt  output  ADDR_WIDTH  beats accepted since the last arm.
- checksum  output  32  running checksum.
- busy  output  1  high while in RECV.
- done  output  1  one-cycle pulse when the last beat is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; M_Ready=0, busy=0, done=0, beat_cnt=0, checksum=0, rd_data=0, latched target=0. RAM contents are not cleared.
- States: IDLE, RECV, DONE.
  - IDLE: on DMA_write_valid=1, latch target=result_num, clear beat_cnt and checksum.
    - target!=0 -> RECV.
    - target==0 -> DONE; done pulses the following cycle.
  - RECV: M_Ready=1 (registered, asserted the cycle after entry).
    - A beat is accepted when M_Valid&M_Ready are high at a clk edge.
    - On acceptance: RAM[beat_cnt]<=M_Data; beat_cnt++; checksum <= checksum + sum of all 32-bit lanes of M_Data, mod 2^32.
    - When the accepted beat makes beat_cnt==target: go to DONE and drop M_Ready in the same edge, so no extra beat is taken.
  - DONE: done=1 for exactly one cycle, then IDLE. beat_cnt and checksum hold their values until the next arm.
- DMA_write_valid in RECV or DONE is ignored; no re-latching.
- M_Valid while not in RECV is never accepted (M_Ready=0). The sink does not require the source to hold M_Data stable.
- RAM writes are limited to addresses < RAM_DEPTH. Beats beyond RAM_DEPTH are counted and checksummed but not stored.
- Readback: rd_data<=RAM[rd_addr] on every clk edge. Out-of-range rd_addr returns 0. Readback is allowed in any state.
- Simultaneous write and read of the same address returns the old data (read-first).
- Reset mid-RECV: returns to IDLE immediately and M_Ready drops asynchronously. Data already written stays in RAM.

Optional Feature:
- Macro: BACKPRESSURE_EN.
- With the macro: a 16-bit Fibonacci LFSR (taps 16,14,13,11) loaded with LFSR_SEED on reset and on arm advances every cycle in RECV. M_Ready = RECV & lfsr[0], giving random stalls. Completion and data rules are unchanged.
- Without the macro: no LFSR logic is present, and M_Ready is a constant 1 throughout RECV.

Test Plan:
- Arm with result_num=4, send beats with lane values {1,2,3,4}, {5,6,7,8}, {0,0,0,0}, {FFFFFFFF,1,0,0}, M_Valid held high -> done pulses once, beat_cnt=4, checksum=0x00000024, readback of addresses 0..3 matches the beats, M_Ready=0 after the 4th beat.
- Arm with result_num=3, source keeps M_Valid=1 for 5 beats -> only 3 beats accepted, beats 4 and 5 see M_Ready=0, beat_cnt=3.
- Arm with result_num=0 -> busy never rises, done pulses within 2 cycles, beat_cnt=0.
- Assert rst=0 after 2 of 8 beats, then re-arm with result_num=2 -> old RAM[0..1] are overwritten, beat_cnt=2, checksum covers only the new beats.
- Pulse DMA_write_valid again in mid-RECV with result_num=100 -> ignored; the transfer completes at the original target of 6.
- With BACKPRESSURE_EN defined, result_num=64 of incrementing data -> M_Ready shows stalls, all 64 beats are stored in order, and the checksum matches a software sum.
